idwt_1d1l: RTL and testbench

One-level 1-D inverse integer Haar (S-transform) reconstruction stage, placed directly downstream of the one-level forward DWT stage. Accepts one (low, high) coefficient pair per handshake and rebuilds the two original samples x[2n], x[2n+1]. Emits them serially, one per handshake, marking the last sample of each frame.

---
 rtl/dwt_pkg.sv | 31 +++
 rtl/idwt_lift.sv | 65 ++++++
 rtl/idwt_1d1l.sv | 155 +++++++++++++++
 tb/tb_idwt_1d1l.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dwt_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : dwt_pkg
//  Description : Shared definitions for the forward / inverse 1-D Haar
//                (S-transform) DWT stages: default sample width, emitter FSM
//                state encoding and the lifting datapath width.
//  Revision    : 1.0 - initial release
// ============================================================================
package dwt_pkg;

  // Default sample / low-band width shared by both transform stages.
  localparam int c_DATA_W_DEFAULT = 8;

  // Extra bits carried by the lifting datapath: one for the sign and one for
  // the growth of a = low + ceil(high/2) beyond the sample range.
  localparam int c_LIFT_GUARD = 2;

  // Serial sample emitter states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EMIT_A = 2'd1,
    EMIT_B = 2'd2
  } dwt_state_t;

  // Signed width of the lifting datapath for a given sample width.
  function automatic int lift_width(input int data_w);
    return data_w + c_LIFT_GUARD;
  endfunction

endpackage
`default_nettype wire

// File: rtl/idwt_lift.sv
`default_nettype none
// ============================================================================
//  Module      : idwt_lift
//  Description : Combinational inverse integer Haar lifting step.
//                b = low - floor(high/2), a = b + high, evaluated signed at
//                DATA_W+2 bits, then reduced to DATA_W bits.
//                Build option IDWT_CLAMP_EN: saturate a/b to [0, 2^DATA_W-1]
//                and report clamping on o_clamp; otherwise wrap modulo
//                2^DATA_W and the o_clamp port is absent.
//  Revision    : 1.0 - initial release
// ============================================================================
module idwt_lift
  import dwt_pkg::*;
#(
  parameter int DATA_W = c_DATA_W_DEFAULT
) (
  input  logic [DATA_W-1:0] i_low,
  input  logic [DATA_W:0]   i_high,
  output logic [DATA_W-1:0] o_a,
`ifdef IDWT_CLAMP_EN
  output logic              o_clamp,
`endif
  output logic [DATA_W-1:0] o_b
);

  localparam int c_LW = lift_width(DATA_W);

  logic signed [c_LW-1:0] w_low;
  logic signed [c_LW-1:0] w_high;
  logic signed [c_LW-1:0] w_b;
  logic signed [c_LW-1:0] w_a;

  // Low band is unsigned: zero-extend. High band is two's complement: sign-extend.
  assign w_low  = $signed({{c_LIFT_GUARD{1'b0}}, i_low});
  assign w_high = $signed({{(c_LW-DATA_W-1){i_high[DATA_W]}}, i_high});

  // Arithmetic shift of a signed operand rounds toward minus infinity.
  assign w_b = w_low - (w_high >>> 1);
  assign w_a = w_b + w_high;

`ifdef IDWT_CLAMP_EN
  localparam logic signed [c_LW-1:0] c_MAXV = c_LW'((1 << DATA_W) - 1);

  // Saturate a signed lifting result into the unsigned sample range.
  function automatic logic [DATA_W-1:0] f_sat(input logic signed [c_LW-1:0] v);
    if (v < 0) begin
      return '0;
    end else if (v > c_MAXV) begin
      return '1;
    end else begin
      return v[DATA_W-1:0];
    end
  endfunction

  assign o_a     = f_sat(w_a);
  assign o_b     = f_sat(w_b);
  assign o_clamp = (w_a < 0) || (w_a > c_MAXV) || (w_b < 0) || (w_b > c_MAXV);
`else
  // Modular reduction: keep the low DATA_W bits.
  assign o_a = DATA_W'(w_a);
  assign o_b = DATA_W'(w_b);
`endif

endmodule
`default_nettype wire

// File: rtl/idwt_1d1l.sv
`default_nettype none
// ============================================================================
//  Module      : idwt_1d1l
//  Description : One-level 1-D inverse integer Haar reconstruction stage.
//                Accepts one (low, high) pair per handshake, rebuilds
//                x[2n] (a) and x[2n+1] (b) and emits them serially, flagging
//                the last sample of each FRAME_PAIRS-pair frame on last_o.
//                A new pair may be loaded while b is handshaked, giving one
//                sample per cycle with sample_ready_i held high.
//                Build option IDWT_CLAMP_EN: saturating reconstruction with a
//                one-cycle sat_o pulse after loading a clamped pair;
//                otherwise modular reconstruction and sat_o tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module idwt_1d1l
  import dwt_pkg::*;
#(
  parameter int DATA_W      = c_DATA_W_DEFAULT,
  parameter int FRAME_PAIRS = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [DATA_W-1:0] low_i,
  input  logic [DATA_W:0]   high_i,
  input  logic              coef_valid_i,
  output logic              coef_ready_o,
  output logic [DATA_W-1:0] sample_o,
  output logic              sample_valid_o,
  input  logic              sample_ready_i,
  output logic              last_o,
  output logic              sat_o
);

  localparam int                 c_CNT_W    = (FRAME_PAIRS > 1) ? $clog2(FRAME_PAIRS) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(FRAME_PAIRS - 1);

  dwt_state_t         r_state;
  dwt_state_t         w_state_nxt;
  logic [DATA_W-1:0]  r_a;
  logic [DATA_W-1:0]  r_b;
  logic [c_CNT_W-1:0] r_cnt;
  logic [DATA_W-1:0]  w_a;
  logic [DATA_W-1:0]  w_b;
  logic               w_load;
  logic               w_b_hs;

`ifdef IDWT_CLAMP_EN
  logic               w_clamp;
  logic               r_sat;
`endif

  idwt_lift #(
    .DATA_W (DATA_W)
  ) u_lift (
    .i_low   (low_i),
    .i_high  (high_i),
    .o_a     (w_a),
`ifdef IDWT_CLAMP_EN
    .o_clamp (w_clamp),
`endif
    .o_b     (w_b)
  );

  // Emitter state register.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, handshake and output decode; sample_o only ever muxes registers.
  always_comb begin
    w_state_nxt    = r_state;
    w_load         = 1'b0;
    w_b_hs         = 1'b0;
    coef_ready_o   = 1'b0;
    sample_valid_o = 1'b0;
    sample_o       = '0;
    case (r_state)
      IDLE: begin
        coef_ready_o = 1'b1;
        if (coef_valid_i) begin
          w_load      = 1'b1;
          w_state_nxt = EMIT_A;
        end
      end
      EMIT_A: begin
        sample_o       = r_a;
        sample_valid_o = 1'b1;
        if (sample_ready_i) begin
          w_state_nxt = EMIT_B;
        end
      end
      EMIT_B: begin
        sample_o       = r_b;
        sample_valid_o = 1'b1;
        // The pair registers free up exactly when b leaves.
        coef_ready_o   = sample_ready_i;
        if (sample_ready_i) begin
          w_b_hs = 1'b1;
          if (coef_valid_i) begin
            w_load      = 1'b1;
            w_state_nxt = EMIT_A;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Capture the reconstructed pair when a coefficient pair is accepted.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_a <= '0;
      r_b <= '0;
    end else if (w_load) begin
      r_a <= w_a;
      r_b <= w_b;
    end
  end

  // Pair position within the frame, advanced when b is handshaked.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_cnt <= '0;
    end else if (w_b_hs) begin
      r_cnt <= (r_cnt == c_CNT_LAST) ? '0 : r_cnt + c_CNT_W'(1);
    end
  end

  assign last_o = (r_state == EMIT_B) && (r_cnt == c_CNT_LAST);

`ifdef IDWT_CLAMP_EN
  // One-cycle saturation flag following the load of a clamped pair.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_sat <= 1'b0;
    end else begin
      r_sat <= w_load & w_clamp;
    end
  end

  assign sat_o = r_sat;
`else
  assign sat_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_idwt_1d1l.sv
`default_nettype none
// ============================================================================
//  Module      : tb_idwt_1d1l
//  Description : Self-checking bench for idwt_1d1l (FRAME_PAIRS = 4).
//                Accepted pairs push expected samples into a queue; emitted
//                samples are popped and compared. Honours IDWT_CLAMP_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_idwt_1d1l;

  localparam int DATA_W      = 8;
  localparam int FRAME_PAIRS = 4;
  localparam int MAXV        = (1 << DATA_W) - 1;

  logic              sys_clk        = 1'b0;
  logic              sys_rst        = 1'b1;
  logic [DATA_W-1:0] low_i          = '0;
  logic [DATA_W:0]   high_i         = '0;
  logic              coef_valid_i   = 1'b0;
  logic              coef_ready_o;
  logic [DATA_W-1:0] sample_o;
  logic              sample_valid_o;
  logic              sample_ready_i = 1'b1;
  logic              last_o;
  logic              sat_o;

  idwt_1d1l #(
    .DATA_W      (DATA_W),
    .FRAME_PAIRS (FRAME_PAIRS)
  ) dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .low_i          (low_i),
    .high_i         (high_i),
    .coef_valid_i   (coef_valid_i),
    .coef_ready_o   (coef_ready_o),
    .sample_o       (sample_o),
    .sample_valid_o (sample_valid_o),
    .sample_ready_i (sample_ready_i),
    .last_o         (last_o),
    .sat_o          (sat_o)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [DATA_W-1:0] val;
    logic              last;
    bit                is_a;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  bit   rand_ready  = 1'b0;
  logic ready_level = 1'b1;

  // monitor state
  int                m_pair;
  bit                exp_sat;
  bit                prev_stall;
  logic [DATA_W-1:0] prev_sample;
  logic              prev_last;
  int                m_lo, m_hi, m_a, m_b;
  exp_t              m_e;

  // Reference reconstruction helpers
  function automatic int floor_half(input int h);
    return (h < 0) ? (h - 1) / 2 : h / 2;
  endfunction

  function automatic logic [DATA_W-1:0] fix(input int v);
`ifdef IDWT_CLAMP_EN
    if (v < 0) return '0;
    if (v > MAXV) return '1;
    return DATA_W'(v);
`else
    return DATA_W'(v & MAXV);
`endif
  endfunction

  function automatic bit will_sat(input int a, input int b);
`ifdef IDWT_CLAMP_EN
    return (a < 0) || (a > MAXV) || (b < 0) || (b > MAXV);
`else
    return 1'b0;
`endif
  endfunction

  // Downstream ready: fixed level or random stalls, changed after each edge
  always @(posedge sys_clk) begin
    #3;
    if (rand_ready) sample_ready_i = ($urandom_range(0, 2) != 0);
    else            sample_ready_i = ready_level;
  end

  // Scoreboard monitor, sampling mid-cycle
  always @(negedge sys_clk) begin
    if (sys_rst) begin
      m_pair     = 0;
      exp_sat    = 1'b0;
      prev_stall = 1'b0;
    end else begin
      n_checks++;
      if (sat_o !== exp_sat) begin
        n_errors++;
        $display("FAIL sat_o: got %b expected %b at %0t", sat_o, exp_sat, $time);
      end
      if (prev_stall) begin
        n_checks++;
        if (sample_valid_o !== 1'b1 || sample_o !== prev_sample || last_o !== prev_last) begin
          n_errors++;
          $display("FAIL stall_hold: got v=%b d=%0d l=%b expected v=1 d=%0d l=%b at %0t",
                   sample_valid_o, sample_o, last_o, prev_sample, prev_last, $time);
        end
      end
      if (sample_valid_o === 1'b1 && sb.size() > 0 && sb[0].is_a) begin
        n_checks++;
        if (coef_ready_o !== 1'b0) begin
          n_errors++;
          $display("FAIL ready_in_emit_a: got %b expected 0 at %0t", coef_ready_o, $time);
        end
      end
      exp_sat = 1'b0;
      if (coef_valid_i === 1'b1 && coef_ready_o === 1'b1) begin
        m_lo = int'(low_i);
        m_hi = int'($signed(high_i));
        m_b  = m_lo - floor_half(m_hi);
        m_a  = m_b + m_hi;
        sb.push_back('{val: fix(m_a), last: 1'b0, is_a: 1'b1});
        sb.push_back('{val: fix(m_b), last: (m_pair == FRAME_PAIRS - 1), is_a: 1'b0});
        m_pair  = (m_pair == FRAME_PAIRS - 1) ? 0 : m_pair + 1;
        exp_sat = will_sat(m_a, m_b);
      end
      if (sample_valid_o === 1'b1 && sample_ready_i === 1'b1) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_sample: got %0d expected none at %0t", sample_o, $time);
        end else begin
          m_e = sb.pop_front();
          if (sample_o !== m_e.val || last_o !== m_e.last) begin
            n_errors++;
            $display("FAIL sample: got %0d last=%b expected %0d last=%b at %0t",
                     sample_o, last_o, m_e.val, m_e.last, $time);
          end
        end
      end
      prev_stall  = (sample_valid_o === 1'b1) && (sample_ready_i !== 1'b1);
      prev_sample = sample_o;
      prev_last   = last_o;
    end
  end

  // Present one pair and hold it until accepted (bounded)
  task automatic drive_pair(input int lo, input int hi);
    int guard;
    guard        = 0;
    low_i        = DATA_W'(lo);
    high_i       = (DATA_W+1)'(hi);
    coef_valid_i = 1'b1;
    @(negedge sys_clk);
    while (coef_ready_o !== 1'b1 && guard < 200) begin
      @(negedge sys_clk);
      guard++;
    end
    if (coef_ready_o !== 1'b1) begin
      n_errors++;
      $display("FAIL accept_timeout: got ready=%b expected 1", coef_ready_o);
    end
    @(posedge sys_clk);
    #2;
    coef_valid_i = 1'b0;
  endtask

  task automatic drive_random_pair();
    drive_pair(int'($urandom_range(0, MAXV)), int'($urandom_range(0, 2 * MAXV + 1)) - (MAXV + 1));
  endtask

  // Wait until every expected sample has left the DUT (bounded)
  task automatic wait_drain();
    int guard;
    guard = 0;
    while ((sb.size() != 0 || sample_valid_o === 1'b1) && guard < 2000) begin
      @(posedge sys_clk);
      #1;
      guard++;
    end
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
  endtask

  task automatic pulse_reset();
    @(posedge sys_clk);
    #2;
    sys_rst = 1'b1;
    @(posedge sys_clk);
    #2;
    sys_rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge sys_clk);
    #1;
    n_checks++; if (sample_valid_o !== 1'b0) begin n_errors++; $display("FAIL rst_valid: got %b expected 0", sample_valid_o); end
    n_checks++; if (coef_ready_o !== 1'b1) begin n_errors++; $display("FAIL rst_ready: got %b expected 1", coef_ready_o); end
    n_checks++; if (sample_o !== '0) begin n_errors++; $display("FAIL rst_sample: got %0d expected 0", sample_o); end
    n_checks++; if (last_o !== 1'b0) begin n_errors++; $display("FAIL rst_last: got %b expected 0", last_o); end
    n_checks++; if (sat_o !== 1'b0) begin n_errors++; $display("FAIL rst_sat: got %b expected 0", sat_o); end
    @(posedge sys_clk);
    #2;
    sys_rst = 1'b0;
    #1;
    n_checks++; if (coef_ready_o !== 1'b1) begin n_errors++; $display("FAIL post_rst_ready: got %b expected 1", coef_ready_o); end
    n_checks++; if (sample_valid_o !== 1'b0) begin n_errors++; $display("FAIL post_rst_valid: got %b expected 0", sample_valid_o); end
    @(posedge sys_clk);
    #2;
  endtask

  task automatic test_basic();
    drive_pair(80, 40);
    #1;
    n_checks++; if (sample_valid_o !== 1'b1) begin n_errors++; $display("FAIL first_latency_valid: got %b expected 1", sample_valid_o); end
    n_checks++; if (sample_o !== 8'd100) begin n_errors++; $display("FAIL first_latency_a: got %0d expected 100", sample_o); end
    drive_pair(6, -7);
    drive_pair(255, -2);
    wait_drain();
  endtask

  task automatic test_frame();
    int got, good_last, bad_last, bub, guard;
    bit started;
    got = 0; good_last = 0; bad_last = 0; bub = 0; guard = 0; started = 1'b0;
    pulse_reset();
    fork
      begin
        for (int i = 0; i < 9; i++) drive_random_pair();
      end
      begin
        while (got < 18 && guard < 500) begin
          @(negedge sys_clk);
          guard++;
          if (sample_valid_o === 1'b1 && sample_ready_i === 1'b1) begin
            got++;
            started = 1'b1;
            if (last_o === 1'b1) begin
              if (got == 8 || got == 16) good_last++;
              else bad_last++;
            end
          end else if (started) begin
            bub++;
          end
        end
      end
    join
    wait_drain();
    n_checks++; if (got != 18) begin n_errors++; $display("FAIL frame_count: got %0d expected 18", got); end
    n_checks++; if (good_last != 2) begin n_errors++; $display("FAIL frame_last_hits: got %0d expected 2", good_last); end
    n_checks++; if (bad_last != 0) begin n_errors++; $display("FAIL frame_last_spurious: got %0d expected 0", bad_last); end
    n_checks++; if (bub != 0) begin n_errors++; $display("FAIL frame_bubbles: got %0d expected 0", bub); end
  endtask

  task automatic test_stall();
    rand_ready = 1'b1;
    for (int i = 0; i < 24; i++) drive_random_pair();
    wait_drain();
    rand_ready = 1'b0;
    @(posedge sys_clk);
    #2;
  endtask

  task automatic test_reset_mid();
    int got, last_at, guard;
    got = 0; last_at = -1; guard = 0;
    pulse_reset();
    ready_level = 1'b0;
    drive_pair(10, 4);
    n_checks++; if (sample_valid_o !== 1'b1 || sample_o !== 8'd12) begin n_errors++; $display("FAIL mid_pre: got v=%b d=%0d expected v=1 d=12", sample_valid_o, sample_o); end
    sys_rst = 1'b1;
    #1;
    n_checks++; if (sample_valid_o !== 1'b0) begin n_errors++; $display("FAIL mid_rst_valid: got %b expected 0", sample_valid_o); end
    n_checks++; if (coef_ready_o !== 1'b1) begin n_errors++; $display("FAIL mid_rst_ready: got %b expected 1", coef_ready_o); end
    @(posedge sys_clk);
    #2;
    sys_rst     = 1'b0;
    sb.delete();
    ready_level = 1'b1;
    fork
      begin
        for (int i = 0; i < 4; i++) drive_random_pair();
      end
      begin
        while (got < 8 && guard < 500) begin
          @(negedge sys_clk);
          guard++;
          if (sample_valid_o === 1'b1 && sample_ready_i === 1'b1) begin
            got++;
            if (last_o === 1'b1 && last_at < 0) last_at = got;
          end
        end
      end
    join
    wait_drain();
    n_checks++; if (last_at != 8) begin n_errors++; $display("FAIL mid_new_frame_last: got %0d expected 8", last_at); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_frame();
    test_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
